// File: rtl/conv2d_pkg.sv
// -----------------------------------------------------------------------------
// conv2d_pkg
// Shared definitions for the Conv2d window sequencer: default image geometry,
// derived counter/coordinate widths, and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package conv2d_pkg;

    localparam int DEF_IMG_W = 32;
    localparam int DEF_IMG_H = 32;
    localparam int DEF_K     = 3;

    // Bit width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Derived widths for the default geometry.
    localparam int DEF_ROW_CNT_W = width_of(DEF_IMG_H);
    localparam int DEF_COL_CNT_W = width_of(DEF_IMG_W);
    localparam int DEF_OUT_ROW_W = width_of(DEF_IMG_H - DEF_K + 1);
    localparam int DEF_OUT_COL_W = width_of(DEF_IMG_W - DEF_K + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/window_tag_delay.sv
// -----------------------------------------------------------------------------
// window_tag_delay
// Fixed-depth shift register that carries the window tag {valid, last, row,
// col} alongside the line buffer + MAC pipeline so the tag emerges in the same
// cycle as the matching convolution result.
// Ports:
//   clk, reset          : clock, synchronous active-high clear
//   valid_i/last_i      : tag flags for the window pushed this cycle
//   row_i/col_i         : output coordinates for that window
//   valid_o/last_o/
//   row_o/col_o         : the same tag, DEPTH cycles later
// -----------------------------------------------------------------------------
module window_tag_delay #(
    parameter int DEPTH = 1,
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] col_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o
);

    localparam int TAG_W = ROW_W + COL_W + 2;

    logic [TAG_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every stage is cleared, not just left to flush: a stale
            // valid bit here would emit a phantom output after a mid-frame abort.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage read the previous
            // stage's old value, which is what makes this a shift register.
            stage_q[0] <= {valid_i, last_i, row_i, col_i};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {valid_o, last_o, row_o, col_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv_window_sequencer
// Consumer-side controller for the 3x3 double line buffer. Tracks the raster
// position of each pushed pixel, tags geometrically valid windows, delays the
// tag to line up with the MAC result, and registers result + coordinates.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   in_valid     : a pixel is pushed into the line buffer this cycle
//   conv_result  : MAC output, aligned 1+MAC_LAT cycles after the push
//   out_data     : registered conv_result of a valid window (holds otherwise)
//   out_valid    : out_data/out_row/out_col valid this cycle
//   out_row/col  : output coordinates of the window (hold when not valid)
//   frame_done   : one-cycle pulse with the last out_valid of a frame
//   busy         : high from first pixel of a frame until after frame_done
//   err_gap      : sticky, in_valid dropped mid-frame; cleared only by reset
// -----------------------------------------------------------------------------
module conv_window_sequencer
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int K          = DEF_K,
    parameter int MAC_LAT    = 0,
    parameter int ROW_W      = width_of(IMG_H - K + 1),
    parameter int COL_W      = width_of(IMG_W - K + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] conv_result,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_gap
);

    localparam int RC_W = width_of(IMG_H);
    localparam int CC_W = width_of(IMG_W);

    seq_state_e            state_q, state_d;
    logic [RC_W-1:0]       row_cnt_q, row_cnt_d;
    logic [CC_W-1:0]       col_cnt_q, col_cnt_d;
    logic                  err_gap_q, err_gap_d;

    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic [ROW_W-1:0]      out_row_q;
    logic [COL_W-1:0]      out_col_q;
    logic                  frame_done_q;

    logic                  col_at_end, row_at_end, last_px;
    logic                  win_valid;
    logic [ROW_W-1:0]      win_row;
    logic [COL_W-1:0]      win_col;

    logic                  tag_valid, tag_last;
    logic [ROW_W-1:0]      tag_row;
    logic [COL_W-1:0]      tag_col;

    // Window geometry of the pixel being pushed this cycle. A window is only
    // complete once K-1 full rows and K-1 pixels of the current row exist;
    // earlier columns straddle the previous row's tail.
    assign col_at_end = (col_cnt_q == CC_W'(IMG_W - 1));
    assign row_at_end = (row_cnt_q == RC_W'(IMG_H - 1));
    assign last_px    = in_valid && row_at_end && col_at_end;
    assign win_valid  = in_valid && (row_cnt_q >= RC_W'(K - 1))
                                 && (col_cnt_q >= CC_W'(K - 1));
    assign win_row    = ROW_W'(row_cnt_q - RC_W'(K - 1));
    assign win_col    = COL_W'(col_cnt_q - CC_W'(K - 1));

    // Raster counters advance on every push regardless of state; they wrap to
    // (0,0) after the last pixel, so IDLE and DRAIN always start a frame there.
    always_comb begin
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        if (in_valid) begin
            if (col_at_end) begin
                col_cnt_d = '0;
                row_cnt_d = row_at_end ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        state_d   = state_q;
        err_gap_d = err_gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!in_valid)    err_gap_d = 1'b1;
                else if (last_px) state_d   = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A new frame may start while the old frame's tags drain; the
                // tag pipeline still delivers the old frame_done.
                if (in_valid)          state_d = ST_RUN;
                else if (frame_done_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            err_gap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            err_gap_q <= err_gap_d;
        end
    end

    window_tag_delay #(
        .DEPTH (1 + MAC_LAT),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .valid_i (win_valid),
        .last_i  (last_px),
        .row_i   (win_row),
        .col_i   (win_col),
        .valid_o (tag_valid),
        .last_o  (tag_last),
        .row_o   (tag_row),
        .col_o   (tag_col)
    );

    // Output stage: data and coordinates load only for valid windows and hold
    // otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= tag_valid;
            frame_done_q <= tag_valid && tag_last;
            if (tag_valid) begin
                out_data_q <= conv_result;
                out_row_q  <= tag_row;
                out_col_q  <= tag_col;
            end
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_gap    = err_gap_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_sequencer
// Drives one pixel stream into two sequencers (MAC_LAT=0 and MAC_LAT=4) and
// compares every output, every cycle, against a reference model that derives
// each expected output from the pushed pixel index with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_conv_window_sequencer;

    localparam int DW   = 32;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int N    = W * H;
    localparam int RW   = $clog2(H - 2);
    localparam int CW   = $clog2(W - 2);
    localparam int HIST = 20000;

    typedef struct {
        int t;      // cycle in which the output must appear
        int row;
        int col;
        bit last;
        int dc;     // cycle whose conv_result must be reported
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] conv_result;

    logic [DW-1:0] out_data0, out_data1;
    logic          out_valid0, out_valid1;
    logic [RW-1:0] out_row0, out_row1;
    logic [CW-1:0] out_col0, out_col1;
    logic          frame_done0, frame_done1;
    logic          busy0, busy1;
    logic          err_gap0, err_gap1;

    always #5 clk = ~clk;

    conv_window_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(3), .MAC_LAT(0)
    ) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .conv_result(conv_result),
        .out_data(out_data0), .out_valid(out_valid0), .out_row(out_row0),
        .out_col(out_col0), .frame_done(frame_done0), .busy(busy0), .err_gap(err_gap0)
    );

    conv_window_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .K(3), .MAC_LAT(4)
    ) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .conv_result(conv_result),
        .out_data(out_data1), .out_valid(out_valid1), .out_row(out_row1),
        .out_col(out_col1), .frame_done(frame_done1), .busy(busy1), .err_gap(err_gap1)
    );

    // Reference model state
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            p     = 0;      // pixels counted in the frame in progress
    bit            err_m = 1'b0;
    bit            checking = 1'b0;
    exp_t          q0[$];
    exp_t          q1[$];
    int            drain_until[2];
    logic [DW-1:0] hold_data[2];
    int            hold_row[2];
    int            hold_col[2];
    logic [DW-1:0] cr_hist [HIST];

    // Per-scenario observations
    int            n_out[2];
    int            fd_cnt[2];
    int            fd_last[2];
    int            fd_prev[2];
    int            first_out[2];
    int            first_push;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int d);
        exp_t          e;
        bit            ev;
        logic          ov, ofd, ob, oe;
        logic [DW-1:0] od;
        logic [RW-1:0] orow;
        logic [CW-1:0] ocol;
        if (d == 0) begin
            ov = out_valid0; ofd = frame_done0; ob = busy0; oe = err_gap0;
            od = out_data0;  orow = out_row0;   ocol = out_col0;
        end else begin
            ov = out_valid1; ofd = frame_done1; ob = busy1; oe = err_gap1;
            od = out_data1;  orow = out_row1;   ocol = out_col1;
        end
        ev = 1'b0;
        e  = '{t: 0, row: 0, col: 0, last: 1'b0, dc: 0};
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].t == cyc) begin e = q0.pop_front(); ev = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].t == cyc) begin e = q1.pop_front(); ev = 1'b1; end
        end
        if (ev) begin
            hold_data[d] = cr_hist[e.dc];
            hold_row[d]  = e.row;
            hold_col[d]  = e.col;
        end
        check($sformatf("dut%0d.out_valid", d),  DW'(ov),   DW'(ev));
        check($sformatf("dut%0d.frame_done", d), DW'(ofd),  DW'(ev && e.last));
        check($sformatf("dut%0d.busy", d),       DW'(ob),   DW'((p > 0) || (cyc <= drain_until[d])));
        check($sformatf("dut%0d.err_gap", d),    DW'(oe),   DW'(err_m));
        check($sformatf("dut%0d.out_data", d),   od,        hold_data[d]);
        check($sformatf("dut%0d.out_row", d),    DW'(orow), DW'(hold_row[d]));
        check($sformatf("dut%0d.out_col", d),    DW'(ocol), DW'(hold_col[d]));
        if (ov === 1'b1) begin
            n_out[d]++;
            if (first_out[d] < 0) first_out[d] = cyc;
        end
        if (ofd === 1'b1) begin
            fd_cnt[d]++;
            fd_prev[d] = fd_last[d];
            fd_last[d] = cyc;
        end
    endtask

    // One clock cycle: check outputs of this cycle, apply inputs, then advance
    // the model across the coming rising edge.
    task automatic step(input bit iv, input bit rst);
        exp_t e;
        int   r, c;
        @(negedge clk);
        if (checking) begin
            check_dut(0);
            check_dut(1);
        end
        in_valid    = iv;
        reset       = rst;
        conv_result = $urandom;
        if (cyc < HIST) cr_hist[cyc] = conv_result;
        if (rst) begin
            q0.delete();
            q1.delete();
            p     = 0;
            err_m = 1'b0;
            for (int d = 0; d < 2; d++) begin
                drain_until[d] = -1;
                hold_data[d]   = '0;
                hold_row[d]    = 0;
                hold_col[d]    = 0;
            end
            checking = 1'b1;
        end else if (iv) begin
            if (first_push < 0) first_push = cyc;
            r = p / W;
            c = p % W;
            if (r >= 2 && c >= 2) begin
                for (int d = 0; d < 2; d++) begin
                    e.t    = cyc + 2 + lat_of(d);
                    e.row  = r - 2;
                    e.col  = c - 2;
                    e.last = (p == N - 1);
                    e.dc   = cyc + 1 + lat_of(d);
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            if (p == N - 1) begin
                for (int d = 0; d < 2; d++) drain_until[d] = cyc + 2 + lat_of(d);
                p = 0;
            end else begin
                p++;
            end
        end else if (p > 0) begin
            err_m = 1'b1;
        end
        cyc++;
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_out[d]     = 0;
            fd_cnt[d]    = 0;
            fd_last[d]   = -1;
            fd_prev[d]   = -1;
            first_out[d] = -1;
        end
        first_push = -1;
    endtask

    task automatic check_frames(input string tag, input int exp_out, input int exp_fd);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.dut%0d.n_out", tag, d),  DW'(n_out[d]),  DW'(exp_out));
            check($sformatf("%s.dut%0d.fd_cnt", tag, d), DW'(fd_cnt[d]), DW'(exp_fd));
        end
    endtask

    // First output comes from the push of pixel (2,2), index 2*W+2, and
    // reaches out_valid 2+MAC_LAT cycles after that push.
    task automatic check_first_latency(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.dut%0d.first_lat", tag, d),
                  DW'(first_out[d] - first_push), DW'(2 * W + 2 + 2 + lat_of(d)));
        end
    endtask

    initial begin
        int pushed;
        bit v;
        reset       = 1'b1;
        in_valid    = 1'b0;
        conv_result = '0;
        for (int d = 0; d < 2; d++) drain_until[d] = -1;
        clear_stats();

        // Reset state
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Continuous frame
        clear_stats();
        repeat (N) step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        check_frames("frame1", 900, 1);
        check_first_latency("frame1");

        // Gap of 3 cycles after push index 100
        clear_stats();
        repeat (101) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (N - 101) step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        check_frames("gap", 900, 1);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Reset arriving with push index 500 aborts the frame
        clear_stats();
        repeat (500) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (80) step(1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("abort.dut%0d.fd_cnt", d), DW'(fd_cnt[d]), DW'(0));

        // Fresh frame after the abort
        clear_stats();
        repeat (N) step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        check_frames("fresh", 900, 1);
        check_first_latency("fresh");

        // Two back-to-back frames
        clear_stats();
        repeat (2 * N) step(1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b0);
        check_frames("b2b", 1800, 2);
        for (int d = 0; d < 2; d++)
            check($sformatf("b2b.dut%0d.fd_spacing", d), DW'(fd_last[d] - fd_prev[d]), DW'(N));

        // Randomly gapped frame
        step(1'b0, 1'b1);
        clear_stats();
        pushed = 0;
        for (int i = 0; i < 4 * N && pushed < N; i++) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, 1'b0);
            if (v) pushed++;
        end
        repeat (80) step(1'b0, 1'b0);
        check_frames("rand", 900, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
